alu_sched: RTL and testbench

Sequencer and two-port arbiter for the shared EX-stage ALU. Accepts operation requests from two requesters over valid/ready, grants the ALU round-robin, drives the ALU operand and control inputs for the op's required number of cycles, captures the registered ALU result, and returns it to the winning requester over a valid/ready response channel. MUL is treated as multi-cycle (MUL_LAT); all other ops take one ALU cycle.

---
 rtl/alu_sched.sv | 135 +++++++++++++
 tb/tb_alu_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Round-robin arbiter and sequencer for the shared EX-stage ALU: two requesters,
// one transaction in flight, registered result returned over valid/ready.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_sched #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WORD_SIZE-1:0] req_a0,
  input  logic [WORD_SIZE-1:0] req_b0,
  input  logic [2:0]           req_op0,
  input  logic [WORD_SIZE-1:0] req_a1,
  input  logic [WORD_SIZE-1:0] req_b1,
  input  logic [2:0]           req_op1,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_err,
  output logic                 busy
);

  localparam logic [2:0] ADD_FUNCT3 = 3'b000;
  localparam logic [2:0] SUB_FUNCT3 = 3'b001;
  localparam logic [2:0] AND_FUNCT3 = 3'b010;
  localparam logic [2:0] OR_FUNCT3  = 3'b011;
  localparam logic [2:0] MUL_FUNCT3 = 3'b100;
  localparam logic [3:0] MUL_CNT    = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t               state, next_state;
  logic                 ptr;
  logic                 id;
  logic                 grant;
  logic [WORD_SIZE-1:0] a_q, b_q;
  logic [2:0]           op_q;
  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] sel_a, sel_b;
  logic [2:0]           sel_op;
  logic                 legal;

  // The pointer requester wins when valid; otherwise the other one is offered.
  always_comb begin
    grant  = req_valid[ptr] ? ptr : ~ptr;
    sel_a  = grant ? req_a1  : req_a0;
    sel_b  = grant ? req_b1  : req_b0;
    sel_op = grant ? req_op1 : req_op0;
  end

  assign legal = (op_q == ADD_FUNCT3) || (op_q == SUB_FUNCT3) || (op_q == MUL_FUNCT3) ||
                 (op_q == AND_FUNCT3) || (op_q == OR_FUNCT3);

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ADD_FUNCT3;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req_valid) begin
          next_state = EXEC;
          // Gated by rst so the accept strobe is dead while reset is held.
          req_ready  = rst ? 2'b00 : (grant ? 2'b10 : 2'b01);
        end
      end
      EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = op_q;
        if (cnt == 4'd0) next_state = CAPT;
      end
      CAPT: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_ctrl   = op_q;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = id ? 2'b10 : 2'b01;
        if (resp_ready[id]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id        <= 1'b0;
      cnt       <= 4'd0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ADD_FUNCT3;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id   <= grant;
            ptr  <= ~grant;
            cnt  <= (sel_op == MUL_FUNCT3) ? MUL_CNT : 4'd0;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        CAPT: begin
          resp_data <= legal ? alu_out : '0;
          resp_err  <= ~legal;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with a registered behavioural ALU
// model standing in for the real EX-stage ALU.
module tb_alu_sched;

  localparam logic [2:0] ADD_OP = 3'b000;
  localparam logic [2:0] SUB_OP = 3'b001;
  localparam logic [2:0] AND_OP = 3'b010;
  localparam logic [2:0] OR_OP  = 3'b011;
  localparam logic [2:0] MUL_OP = 3'b100;
  localparam logic [2:0] BAD_OP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [2:0]  req_op0 = ADD_OP, req_op1 = ADD_OP;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out = '0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  alu_sched #(.WORD_SIZE(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unknown control codes return a marker so a missing force-to-zero is visible.
  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
    case (c)
      ADD_OP:  return a + b;
      SUB_OP:  return a - b;
      AND_OP:  return a & b;
      OR_OP:   return a | b;
      MUL_OP:  return a * b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) alu_out <= aluModel(alu_a, alu_b, alu_ctrl);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1);
    req_valid = valid;
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called in the first EXEC cycle; RESP is entered lat+1 edges after the accept edge.
  task automatic expectResp(input string tag, input logic [1:0] who,
                            input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ectrl,
                            input int lat, input logic [31:0] edata, input logic eerr);
    for (int i = 0; i <= lat; i++) begin
      checkOutput({tag, "_alu_a"}, alu_a, ea);
      checkOutput({tag, "_alu_b"}, alu_b, eb);
      checkOutput({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, {29'd0, ectrl});
      checkOutput({tag, "_early_valid"}, {30'd0, resp_valid}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    checkOutput({tag, "_resp_valid"}, {30'd0, resp_valid}, {30'd0, who});
    checkOutput({tag, "_resp_data"}, resp_data, edata);
    checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, {31'd0, eerr});
    checkOutput({tag, "_idle_alu_a"}, alu_a, 32'd0);
  endtask

  task automatic handshake(input string tag, input logic [1:0] who);
    resp_ready = who;
    tick();
    resp_ready = 2'b00;
    checkOutput({tag, "_hs_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_hs_valid"}, {30'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset held with a pending request: nothing may be accepted.
    applyStimulus(2'b01, 32'd5, 32'd7, ADD_OP, 32'd0, 32'd0, ADD_OP);
    tick();
    checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ADD_OP});
    rst = 1'b0;

    // ADD 5,7 from requester 0 alone.
    applyStimulus(2'b01, 32'd5, 32'd7, ADD_OP, 32'd0, 32'd0, ADD_OP);
    checkOutput("add_req_ready", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("add", 2'b01, 32'd5, 32'd7, ADD_OP, 1, 32'd12, 1'b0);
    handshake("add", 2'b01);

    // Fresh reset so the pointer is back at requester 0, then a simultaneous pair.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, 32'd3, 32'd5, SUB_OP, 32'hF0, 32'h0F, OR_OP);
    checkOutput("pair_grant_r0", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b10, 32'd0, 32'd0, ADD_OP, 32'hF0, 32'h0F, OR_OP);
    checkOutput("pair_loser_wait", {30'd0, req_ready}, 32'd0);
    expectResp("sub", 2'b01, 32'd3, 32'd5, SUB_OP, 1, 32'hFFFF_FFFE, 1'b0);
    handshake("sub", 2'b01);
    checkOutput("pair_grant_r1", {30'd0, req_ready}, 32'd2);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("or", 2'b10, 32'hF0, 32'h0F, OR_OP, 1, 32'hFF, 1'b0);
    handshake("or", 2'b10);

    // Second simultaneous pair returns to requester 0; requester 1 then runs MUL.
    applyStimulus(2'b11, 32'hFF00, 32'h0FF0, AND_OP, 32'd6, 32'd7, MUL_OP);
    checkOutput("pair2_grant_r0", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b10, 32'd0, 32'd0, ADD_OP, 32'd6, 32'd7, MUL_OP);
    expectResp("and", 2'b01, 32'hFF00, 32'h0FF0, AND_OP, 1, 32'h0F00, 1'b0);
    handshake("and", 2'b01);
    checkOutput("mul_grant_r1", {30'd0, req_ready}, 32'd2);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("mul", 2'b10, 32'd6, 32'd7, MUL_OP, 3, 32'd42, 1'b0);
    handshake("mul", 2'b10);

    // Illegal op code: driven to the ALU, result forced to zero with error flag.
    applyStimulus(2'b01, 32'd9, 32'd4, BAD_OP, 32'd0, 32'd0, ADD_OP);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("bad", 2'b01, 32'd9, 32'd4, BAD_OP, 1, 32'd0, 1'b1);
    handshake("bad", 2'b01);

    // Long RESP stall with requester 1 waiting and its resp_ready bit set.
    applyStimulus(2'b01, 32'd2, 32'd3, ADD_OP, 32'd0, 32'd0, ADD_OP);
    checkOutput("stall_grant_r0", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b10, 32'd0, 32'd0, ADD_OP, 32'hFF, 32'h0F, AND_OP);
    expectResp("stall", 2'b01, 32'd2, 32'd3, ADD_OP, 1, 32'd5, 1'b0);
    resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_valid", {30'd0, resp_valid}, 32'd1);
      checkOutput("stall_data", resp_data, 32'd5);
      checkOutput("stall_req_ready", {30'd0, req_ready}, 32'd0);
    end
    handshake("stall", 2'b01);
    checkOutput("after_stall_grant_r1", {30'd0, req_ready}, 32'd2);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("and2", 2'b10, 32'hFF, 32'h0F, AND_OP, 1, 32'h0F, 1'b0);
    handshake("and2", 2'b10);

    // Reset in the middle of a MUL: everything drops, no response appears.
    applyStimulus(2'b10, 32'd0, 32'd0, ADD_OP, 32'd6, 32'd7, MUL_OP);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    checkOutput("mid_ctrl", {29'd0, alu_ctrl}, {29'd0, MUL_OP});
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_alu_a", alu_a, 32'd0);
    checkOutput("midrst_alu_b", alu_b, 32'd0);
    checkOutput("midrst_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ADD_OP});
    checkOutput("midrst_resp_data", resp_data, 32'd0);
    checkOutput("midrst_resp_valid", {30'd0, resp_valid}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("post_rst_no_resp", {30'd0, resp_valid}, 32'd0);
      checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
    end
    applyStimulus(2'b01, 32'd1, 32'd1, ADD_OP, 32'd0, 32'd0, ADD_OP);
    checkOutput("fresh_grant", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, ADD_OP, 32'd0, 32'd0, ADD_OP);
    expectResp("fresh", 2'b01, 32'd1, 32'd1, ADD_OP, 1, 32'd2, 1'b0);
    handshake("fresh", 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
